// File: rtl/idelay_tap_cal_if.sv
// Control and status bundle between the tap calibrator and its user.
// master = calibrator side, slave = bring-up logic / delay-line side.
interface idelay_tap_cal_if #(
    parameter int TAP_W = 5
);
    logic             start;
    logic             match;
    logic             dly_ld;
    logic             dly_ce;
    logic             dly_inc;
    logic [TAP_W-1:0] tap;
    logic             busy;
    logic             done;
    logic             fail;
    logic [TAP_W-1:0] win_start;
    logic [TAP_W:0]   win_len;

    modport master (
        input  start, match,
        output dly_ld, dly_ce, dly_inc, tap,
        output busy, done, fail, win_start, win_len
    );

    modport slave (
        output start, match,
        input  dly_ld, dly_ce, dly_inc, tap,
        input  busy, done, fail, win_start, win_len
    );
endinterface

// File: rtl/idelay_tap_cal.sv
// IDELAYE2 tap sweep: finds the longest passing window, then
// reloads the line and steps it to the window centre.
module idelay_tap_cal #(
    parameter int TAPS          = 32,
    parameter int TAP_W         = $clog2(TAPS),
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    idelay_tap_cal_if.master bus
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ?
                             SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] SET_END  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SMP_END  = CNT_W'(SAMPLE_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_SAMPLE,
        ST_STEP,
        ST_EVAL,
        ST_RELOAD,
        ST_SEEK,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0] cnt_q;
    logic             pass_q;
    logic             pass_now;
    logic             start_ok;
    logic             last_smp;

    logic [TAP_W-1:0] tap_q;
    logic [TAP_W-1:0] tap_d;
    logic             ld_q;
    logic             ld_d;
    logic             ce_q;
    logic             ce_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             fail_q;

    logic [TAP_W-1:0] cur_start_q;
    logic [TAP_W:0]   cur_len_q;
    logic [TAP_W:0]   len_inc;
    logic [TAP_W-1:0] best_start_q;
    logic [TAP_W:0]   best_len_q;
    logic [TAP_W-1:0] target_q;
    logic [TAP_W:0]   centre;
    logic [TAP_W-1:0] ws_q;
    logic [TAP_W:0]   wl_q;

    assign bus.dly_ld    = ld_q;
    assign bus.dly_ce    = ce_q;
    assign bus.dly_inc   = ce_q;
    assign bus.tap       = tap_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fail      = fail_q;
    assign bus.win_start = ws_q;
    assign bus.win_len   = wl_q;

    assign start_ok = bus.start &&
                      (state_q inside {ST_IDLE, ST_DONE, ST_FAIL});
    assign last_smp = (state_q == ST_SAMPLE) && (cnt_q == SMP_END);
    assign pass_now = pass_q & bus.match;
    assign len_inc  = cur_len_q + 1'b1;
    assign centre   = {1'b0, best_start_q} + (best_len_q >> 1);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus look-ahead values for the registered outputs.
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        ld_d    = 1'b0;
        ce_d    = 1'b0;
        busy_d  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (bus.start) state_d = ST_LOAD;
            end
            ST_LOAD:   state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (cnt_q == SET_END) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (cnt_q == SMP_END) begin
                    state_d = (tap_q == LAST_TAP) ? ST_EVAL : ST_STEP;
                end
            end
            ST_STEP:   state_d = ST_SETTLE;
            ST_EVAL: begin
                state_d = (best_len_q == '0) ? ST_FAIL : ST_RELOAD;
            end
            ST_RELOAD: state_d = ST_SEEK;
            ST_SEEK: begin
                if (tap_q == target_q) state_d = ST_DONE;
            end
            default:   state_d = ST_IDLE;
        endcase

        // Tap follows the pulse that was driven during this cycle.
        if (state_d == ST_LOAD || state_d == ST_RELOAD) begin
            tap_d = '0;
        end else if (ce_q) begin
            tap_d = tap_q + 1'b1;
        end

        ld_d   = (state_d == ST_LOAD) || (state_d == ST_RELOAD);
        ce_d   = (state_d == ST_STEP) ||
                 ((state_d == ST_SEEK) && (tap_d != target_q));
        busy_d = state_d inside {ST_LOAD, ST_SETTLE, ST_SAMPLE,
                                 ST_STEP, ST_EVAL, ST_RELOAD, ST_SEEK};
    end

    // Registered outputs, dwell counter and window bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            pass_q       <= 1'b1;
            tap_q        <= '0;
            ld_q         <= 1'b0;
            ce_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            target_q     <= '0;
            ws_q         <= '0;
            wl_q         <= '0;
        end else begin
            tap_q  <= tap_d;
            ld_q   <= ld_d;
            ce_q   <= ce_d;
            busy_q <= busy_d;
            done_q <= (state_d == ST_DONE);
            fail_q <= (state_d == ST_FAIL);

            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == ST_SETTLE || state_q == ST_SAMPLE) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (state_q == ST_SAMPLE && !last_smp) begin
                pass_q <= pass_now;
            end else begin
                pass_q <= 1'b1;
            end

            if (start_ok) begin
                cur_start_q  <= '0;
                cur_len_q    <= '0;
                best_start_q <= '0;
                best_len_q   <= '0;
                ws_q         <= '0;
                wl_q         <= '0;
            end else if (last_smp) begin
                if (pass_now) begin
                    cur_len_q <= len_inc;
                    if (cur_len_q == '0) cur_start_q <= tap_q;
                    // Strictly greater: ties keep the earlier window.
                    if (len_inc > best_len_q) begin
                        best_len_q   <= len_inc;
                        best_start_q <= (cur_len_q == '0) ?
                                        tap_q : cur_start_q;
                    end
                end else begin
                    cur_len_q <= '0;
                end
            end else if (state_q == ST_EVAL && best_len_q != '0) begin
                ws_q     <= best_start_q;
                wl_q     <= best_len_q;
                target_q <= centre[TAP_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_idelay_tap_cal.sv
// Scoreboard bench for idelay_tap_cal: default 32-tap build plus
// a reduced 8-tap build, with a per-cycle pulse protocol monitor.
module tb_idelay_tap_cal;

    localparam int TAPS = 32;
    localparam int S    = 8;
    localparam int P    = 16;
    localparam int SWP  = 1 + TAPS * (S + P) + (TAPS - 1);

    typedef struct {
        int ws;
        int wl;
        int tp;
        bit dn;
        bit fl;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    idelay_tap_cal_if #(.TAP_W(5)) bus ();
    idelay_tap_cal_if #(.TAP_W(3)) sbus ();

    idelay_tap_cal #(
        .TAPS(32), .TAP_W(5), .SETTLE_CYCLES(8), .SAMPLE_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    idelay_tap_cal #(
        .TAPS(8), .TAP_W(3), .SETTLE_CYCLES(1), .SAMPLE_CYCLES(1)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .bus(sbus)
    );

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic exp_t mk(input int ws, input int wl, input int tp,
                                input bit fl);
        exp_t e;
        e.ws  = ws;
        e.wl  = wl;
        e.tp  = tp;
        e.dn  = !fl;
        e.fl  = fl;
        e.cyc = fl ? SWP + 2 : SWP + 4 + tp;
        return e;
    endfunction

    // One calibration on the 32-tap build; poke=1 pulses start at
    // tap 4 and reset at tap 7 instead of running to completion.
    task automatic run(input string nm, input logic [63:0] mask,
                       input int gtap, input bit poke, input exp_t ein);
        exp_t e;
        int   n, ldc, cec, last, gcnt;
        bit   fin, seen4, m;
        if (!poke) sbq.push_back(ein);
        ldc = 0; cec = 0; last = 0; gcnt = 0; fin = 0; seen4 = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.match = mask[bus.tap];
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (!fin) begin
            if (n > 3000) begin
                total++; bad++;
                $display("FAIL %s timeout: busy=%0b want idle", nm, bus.busy);
                fin = 1;
            end else begin
                total++;
                if (bus.dly_inc && !bus.dly_ce) begin
                    bad++;
                    $display("FAIL %s inc_without_ce at cycle %0d", nm, n);
                end
                total++;
                if (bus.dly_ce && bus.dly_ld) begin
                    bad++;
                    $display("FAIL %s ce_with_ld at cycle %0d", nm, n);
                end
                total++;
                if (bus.dly_ce && bus.tap == 5'(TAPS - 1)) begin
                    bad++;
                    $display("FAIL %s step_at_last_tap at cycle %0d", nm, n);
                end
                if (bus.dly_ld) begin
                    ldc++;
                    last = n;
                end
                if (bus.dly_ce) begin
                    if (ldc < 2) begin
                        total++;
                        if (n - last != S + P + 1) begin
                            bad++;
                            $display("FAIL %s step_spacing got %0d want %0d",
                                     nm, n - last, S + P + 1);
                        end
                        last = n;
                    end else begin
                        cec++;
                    end
                end
                if (n == 1) begin
                    total++;
                    if ({bus.busy, bus.dly_ld, bus.done, bus.fail, bus.tap}
                        !== {1'b1, 1'b1, 1'b0, 1'b0, 5'd0}) begin
                        bad++;
                        $display("FAIL %s first_cycle got b%0b l%0b d%0b f%0b t%0d want b1 l1 d0 f0 t0",
                                 nm, bus.busy, bus.dly_ld, bus.done,
                                 bus.fail, bus.tap);
                    end
                end
                m = mask[bus.tap];
                if (int'(bus.tap) == gtap) begin
                    if (gcnt == 12) m = 1'b0;
                    gcnt++;
                end
                bus.match = m;
                if (poke && !seen4 && bus.tap == 5'd4) begin
                    seen4 = 1;
                    bus.start = 1'b1;
                end else begin
                    bus.start = 1'b0;
                end
                if (poke && bus.tap == 5'd7) begin
                    total++;
                    if (ldc != 1) begin
                        bad++;
                        $display("FAIL %s busy_start_ignored ld_count got %0d want 1",
                                 nm, ldc);
                    end
                    rst_n = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    bus.match = 1'b0;
                    bus.start = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        total++;
                        if ({bus.dly_ld, bus.dly_ce, bus.dly_inc, bus.tap,
                             bus.busy, bus.done, bus.fail, bus.win_start,
                             bus.win_len} !== '0) begin
                            bad++;
                            $display("FAIL %s reset_outputs cycle %0d got tap=%0d busy=%0b ld=%0b ce=%0b want all 0",
                                     nm, k, bus.tap, bus.busy, bus.dly_ld,
                                     bus.dly_ce);
                        end
                        @(negedge clk);
                    end
                    fin = 1;
                end else if (!bus.busy) begin
                    fin = 1;
                    total++;
                    if (sbq.size() == 0) begin
                        bad++;
                        $display("FAIL %s scoreboard_empty got 0 want 1", nm);
                    end else begin
                        e = sbq.pop_front();
                        total++;
                        if (int'(bus.win_start) !== e.ws) begin
                            bad++;
                            $display("FAIL %s win_start got %0d want %0d",
                                     nm, bus.win_start, e.ws);
                        end
                        total++;
                        if (int'(bus.win_len) !== e.wl) begin
                            bad++;
                            $display("FAIL %s win_len got %0d want %0d",
                                     nm, bus.win_len, e.wl);
                        end
                        total++;
                        if (int'(bus.tap) !== e.tp) begin
                            bad++;
                            $display("FAIL %s tap got %0d want %0d",
                                     nm, bus.tap, e.tp);
                        end
                        total++;
                        if ({bus.done, bus.fail} !== {e.dn, e.fl}) begin
                            bad++;
                            $display("FAIL %s done_fail got %0b%0b want %0b%0b",
                                     nm, bus.done, bus.fail, e.dn, e.fl);
                        end
                        total++;
                        if (n !== e.cyc) begin
                            bad++;
                            $display("FAIL %s latency got %0d want %0d",
                                     nm, n, e.cyc);
                        end
                        total++;
                        if (ldc !== (e.fl ? 1 : 2)) begin
                            bad++;
                            $display("FAIL %s ld_count got %0d want %0d",
                                     nm, ldc, e.fl ? 1 : 2);
                        end
                        total++;
                        if (cec !== (e.fl ? 0 : e.tp)) begin
                            bad++;
                            $display("FAIL %s seek_pulses got %0d want %0d",
                                     nm, cec, e.fl ? 0 : e.tp);
                        end
                    end
                end else begin
                    n++;
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.match = 1'b0;
        sbus.start = 1'b0;
        sbus.match = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.dly_ld, bus.dly_ce, bus.dly_inc, bus.tap, bus.busy,
             bus.done, bus.fail, bus.win_start, bus.win_len} !== '0) begin
            bad++;
            $display("FAIL reset_big got tap=%0d busy=%0b ld=%0b want all 0",
                     bus.tap, bus.busy, bus.dly_ld);
        end
        total++;
        if ({sbus.dly_ld, sbus.dly_ce, sbus.dly_inc, sbus.tap, sbus.busy,
             sbus.done, sbus.fail, sbus.win_start, sbus.win_len} !== '0) begin
            bad++;
            $display("FAIL reset_small got tap=%0d busy=%0b ld=%0b want all 0",
                     sbus.tap, sbus.busy, sbus.dly_ld);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.busy, bus.dly_ld, bus.dly_ce} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset got %b want 000",
                     {bus.busy, bus.dly_ld, bus.dly_ce});
        end
    endtask

    task automatic test_all_pass;
        run("all_pass", '1, -1, 0, mk(0, 32, 16, 0));
    endtask

    task automatic test_single_window;
        run("single_window", rng(10, 19), -1, 0, mk(10, 10, 15, 0));
    endtask

    task automatic test_tie;
        run("tie", rng(3, 6) | rng(20, 23), -1, 0, mk(3, 4, 5, 0));
    endtask

    task automatic test_glitch;
        run("glitch", rng(8, 20), 12, 0, mk(13, 8, 17, 0));
    endtask

    task automatic test_no_pass;
        run("no_pass", '0, -1, 0, mk(0, 0, 31, 1));
        run("restart_after_fail", rng(10, 19), -1, 0, mk(10, 10, 15, 0));
    endtask

    task automatic test_busy_reset;
        exp_t unused;
        unused = mk(0, 0, 0, 0);
        run("busy_reset", '1, -1, 1, unused);
        run("after_reset", '1, -1, 0, mk(0, 32, 16, 0));
    endtask

    // Reduced build: 8 taps, 1 settle, 1 sample, all passing.
    task automatic test_small_config;
        exp_t e;
        int   n, ldc, cec;
        bit   fin;
        e.ws = 0; e.wl = 8; e.tp = 4; e.dn = 1; e.fl = 0; e.cyc = 32;
        sbq.push_back(e);
        ldc = 0; cec = 0; fin = 0;
        @(negedge clk);
        sbus.start = 1'b1;
        sbus.match = 1'b1;
        @(negedge clk);
        sbus.start = 1'b0;
        n = 1;
        while (!fin) begin
            if (n > 500) begin
                total++; bad++;
                $display("FAIL small timeout: busy=%0b want idle", sbus.busy);
                fin = 1;
            end else begin
                total++;
                if ((sbus.dly_inc && !sbus.dly_ce) ||
                    (sbus.dly_ce && sbus.dly_ld) ||
                    (sbus.dly_ce && sbus.tap == 3'd7)) begin
                    bad++;
                    $display("FAIL small protocol cycle %0d ld=%0b ce=%0b inc=%0b tap=%0d",
                             n, sbus.dly_ld, sbus.dly_ce, sbus.dly_inc,
                             sbus.tap);
                end
                if (sbus.dly_ld) ldc++;
                if (sbus.dly_ce && ldc == 2) cec++;
                if (!sbus.busy) begin
                    fin = 1;
                    e = sbq.pop_front();
                    total++;
                    if ({int'(sbus.tap), int'(sbus.win_start),
                         int'(sbus.win_len)} !== {e.tp, e.ws, e.wl}) begin
                        bad++;
                        $display("FAIL small result got tap=%0d ws=%0d wl=%0d want tap=%0d ws=%0d wl=%0d",
                                 sbus.tap, sbus.win_start, sbus.win_len,
                                 e.tp, e.ws, e.wl);
                    end
                    total++;
                    if ({sbus.done, sbus.fail} !== 2'b10) begin
                        bad++;
                        $display("FAIL small done_fail got %0b%0b want 10",
                                 sbus.done, sbus.fail);
                    end
                    total++;
                    if (n !== e.cyc || ldc !== 2 || cec !== e.tp) begin
                        bad++;
                        $display("FAIL small timing got cyc=%0d ld=%0d seek=%0d want cyc=%0d ld=2 seek=%0d",
                                 n, ldc, cec, e.cyc, e.tp);
                    end
                end else begin
                    n++;
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_single_window();
        test_tie();
        test_glitch();
        test_no_pass();
        test_busy_reset();
        test_small_config();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
